input_conditioner: RTL and testbench

//  N-channel synchronizer + debouncer + edge detector for switches, buttons and PMOD inputs.

---
 rtl/input_conditioner.sv | 128 ++++++++++++
 tb/tb_input_conditioner.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// N-channel synchronizer, debouncer and edge detector with optional auto-repeat strobes.
// Build macro: AUTOREPEAT_EN enables per-channel hold counters; otherwise repeat_o mirrors rise.
module input_conditioner #(
  parameter int unsigned     N_CH          = 8,
  parameter int unsigned     DEBOUNCE_CYC  = 1000000,
  parameter logic [N_CH-1:0] RESET_VALUE   = '0,
  parameter int unsigned     REPEAT_DELAY  = 50000000,
  parameter int unsigned     REPEAT_PERIOD = 10000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] clean,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            changed,
  output logic [N_CH-1:0] repeat_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'((DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0);

  logic [N_CH-1:0]            s1_q, s1_d;
  logic [N_CH-1:0]            s2_q, s2_d;
  logic [N_CH-1:0]            clean_q, clean_d;
  logic [N_CH-1:0]            rise_q, rise_d;
  logic [N_CH-1:0]            fall_q, fall_d;
  logic                       changed_q, changed_d;
  logic [N_CH-1:0]            rpt_q, rpt_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d    = noisy;
    s2_d    = s1_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (s2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TERM) begin
        // Terminal count: commit the new level and emit its edge in the same edge.
        clean_d[i] = s2_q[i];
        cnt_d[i]   = '0;
        rise_d[i]  = s2_q[i];
        fall_d[i]  = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= RESET_VALUE;
      s2_q      <= RESET_VALUE;
      clean_q   <= RESET_VALUE;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      rpt_q     <= '0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      rpt_q     <= rpt_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W   = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] DELAY_LOAD  = HOLD_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [HOLD_W-1:0] PERIOD_LOAD = HOLD_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  logic [N_CH-1:0][HOLD_W-1:0] hold_q, hold_d;

  // Hold counters count down to the next strobe; a fall clears them with no strobe that cycle.
  always_comb begin
    hold_d = hold_q;
    rpt_d  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rise_d[i]) begin
        rpt_d[i]  = 1'b1;
        hold_d[i] = DELAY_LOAD;
      end else if (clean_q[i] && clean_d[i]) begin
        if (hold_q[i] == '0) begin
          rpt_d[i]  = 1'b1;
          hold_d[i] = PERIOD_LOAD;
        end else begin
          hold_d[i] = hold_q[i] - 1'b1;
        end
      end else begin
        hold_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};

  always_comb begin
    rpt_d = rise_d;
  end
`endif

  assign clean    = clean_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign changed  = changed_q;
  assign repeat_o = rpt_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (N_CH=4, DEBOUNCE_CYC=4, REPEAT_DELAY=8, REPEAT_PERIOD=3).
// Define AUTOREPEAT_EN for both files to exercise the auto-repeat build.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] noisy;
  logic [3:0] clean;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       changed;
  logic [3:0] repeat_o;

  int checks   = 0;
  int failures = 0;

  input_conditioner #(
    .N_CH          (4),
    .DEBOUNCE_CYC  (4),
    .RESET_VALUE   (4'b0000),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .noisy    (noisy),
    .clean    (clean),
    .rise     (rise),
    .fall     (fall),
    .changed  (changed),
    .repeat_o (repeat_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       exp_rpt;
    logic [3:0] exp_vec;

    // Reset held for three cycles
    reset = 1'b1;
    noisy = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_clean", 32'(clean), 32'h0);
      chk("rst_rise", 32'(rise), 32'h0);
      chk("rst_fall", 32'(fall), 32'h0);
      chk("rst_repeat", 32'(repeat_o), 32'h0);
      chk("rst_changed", 32'(changed), 32'h0);
    end
    reset = 1'b0;
    tick();
    chk("rst_exit_changed", 32'(changed), 32'h0);

    // Press ch0 and hold: rise after the 6th edge, then auto-repeat, then release
    noisy = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("press_wait_clean", 32'(clean), 32'h0);
      chk("press_wait_changed", 32'(changed), 32'h0);
    end
    for (int j = 0; j <= 22; j++) begin
      tick();
`ifdef AUTOREPEAT_EN
      exp_rpt = (j == 0) || (j == 8) || (j == 11) || (j == 14) || (j == 17);
`else
      exp_rpt = (j == 0);
`endif
      chk("hold_clean0", 32'(clean[0]), 32'(j < 20));
      chk("hold_rise0", 32'(rise[0]), 32'(j == 0));
      chk("hold_fall0", 32'(fall[0]), 32'(j == 20));
      chk("hold_repeat0", 32'(repeat_o[0]), 32'(exp_rpt));
      chk("hold_changed", 32'(changed), 32'((j == 0) || (j == 20)));
      if (j == 14) noisy = 4'b0000;
    end

    // Three-cycle glitch on ch0 must be filtered
    noisy = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("glitch_clean_hi", 32'(clean), 32'h0);
    end
    noisy = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("glitch_clean", 32'(clean), 32'h0);
      chk("glitch_changed", 32'(changed), 32'h0);
      chk("glitch_fall", 32'(fall), 32'h0);
    end

    // Bring clean to 4'b0010
    noisy = 4'b0010;
    for (int i = 1; i <= 5; i++) tick();
    tick();
    chk("setup_clean", 32'(clean), 32'h2);
    chk("setup_rise", 32'(rise), 32'h2);
    tick();
    chk("setup_rise_gone", 32'(rise), 32'h0);

    // Simultaneous fall on ch1 and rise on ch2
    noisy = 4'b0100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("simul_wait_clean", 32'(clean), 32'h2);
      chk("simul_wait_changed", 32'(changed), 32'h0);
    end
    tick();
    exp_vec = 4'b0100;
    chk("simul_clean", 32'(clean), 32'(exp_vec));
    chk("simul_rise", 32'(rise), 32'h4);
    chk("simul_fall", 32'(fall), 32'h2);
    chk("simul_changed", 32'(changed), 32'h1);
    chk("simul_repeat", 32'(repeat_o), 32'h4);
    tick();
    chk("simul_rise_gone", 32'(rise), 32'h0);
    chk("simul_fall_gone", 32'(fall), 32'h0);
    chk("simul_changed_gone", 32'(changed), 32'h0);

    // ch3 press interrupted by reset at count 2
    noisy = 4'b1100;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("mid_wait_clean", 32'(clean), 32'h4);
    end
    reset = 1'b1;
    tick();
    chk("mid_rst_clean", 32'(clean), 32'h0);
    chk("mid_rst_fall", 32'(fall), 32'h0);
    chk("mid_rst_rise", 32'(rise), 32'h0);
    chk("mid_rst_changed", 32'(changed), 32'h0);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("requal_wait_clean", 32'(clean), 32'h0);
      chk("requal_wait_changed", 32'(changed), 32'h0);
    end
    tick();
    chk("requal_clean", 32'(clean), 32'hC);
    chk("requal_rise", 32'(rise), 32'hC);
    chk("requal_changed", 32'(changed), 32'h1);
    tick();
    chk("requal_changed_gone", 32'(changed), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
